cpu_fetch_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/cpu_regfile.sv | 37 +++
 rtl/cpu_fetch_sequencer.sv | 146 ++++++++++++++
 tb/tb_cpu_fetch_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM states and instruction layout for the fetch sequencer.
// Pure declarations: no logic, no latency, no flow control.
package cpu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_LOADI = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam int INSTR_W = 16;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALTED
    } state_t;

    // The LOADI immediate overlays rs2 and the pad bits.
    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [5:0] pad;
    } instr_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// NREGS x DATA_W register file: two combinational operand reads plus a debug read,
// one synchronous write port (visible the cycle after the write), async clear.
module cpu_regfile #(
    parameter int  DATA_W = 8,
    parameter int  NREGS  = 4,
    localparam int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [IDX_W-1:0]  raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [IDX_W-1:0]  dbg_sel_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] rf_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = rf_q[raddr_a_i];
    assign rdata_b_o  = rf_q[raddr_b_i];
    assign dbg_data_o = rf_q[dbg_sel_i];

endmodule

// File: rtl/cpu_fetch_sequencer.sv
// Fetch/decode/writeback controller driving an external registered ALU; ALU op 4 cycles,
// LOADI 3, NOP/HALT 2 with zero-wait memory. FETCH holds req/addr until imem_valid.
module cpu_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  ADDR_W = 8,
    parameter int  NREGS  = 4,
    localparam int IDX_W  = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [3:0]         alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               busy,
    output logic               halted,
    input  logic [IDX_W-1:0]   dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    instr_t              ir_q;
    logic [3:0]          alu_op_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic                imem_req_q;
    logic                busy_q;
    logic                halted_q;

    logic                rf_we;
    logic [DATA_W-1:0]   rf_wdata;
    logic [DATA_W-1:0]   rs1_dat;
    logic [DATA_W-1:0]   rs2_dat;

    assign pc_d = pc_q + ADDR_W'(1);

    // WRITEBACK is only entered for ALU ops and LOADI, so the opcode picks the source.
    always_comb begin
        rf_we    = (state_q == ST_WRITEBACK);
        rf_wdata = alu_result;
        if (ir_q.op == OP_LOADI) begin
            rf_wdata = DATA_W'(ir_q[IMM_MSB:IMM_LSB]);
        end
    end

    cpu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (rf_we),
        .waddr_i    (IDX_W'(ir_q.rd)),
        .wdata_i    (rf_wdata),
        .raddr_a_i  (IDX_W'(ir_q.rs1)),
        .rdata_a_o  (rs1_dat),
        .raddr_b_i  (IDX_W'(ir_q.rs2)),
        .rdata_b_o  (rs2_dat),
        .dbg_sel_i  (dbg_sel),
        .dbg_data_o (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            imem_req_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        state_q    <= ST_FETCH;
                        pc_q       <= '0;
                        imem_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (imem_valid) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (is_alu_op(ir_q.op)) begin
                        alu_op_q <= ir_q.op;
                        alu_a_q  <= rs1_dat;
                        alu_b_q  <= rs2_dat;
                        state_q  <= ST_EXECUTE;
                    end else if (ir_q.op == OP_LOADI) begin
                        state_q <= ST_WRITEBACK;
                    end else if (ir_q.op == OP_HALT) begin
                        state_q  <= ST_HALTED;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q       <= pc_d;
                        imem_req_q <= 1'b1;
                        state_q    <= ST_FETCH;
                    end
                end
                // ALU registers its result on this edge.
                ST_EXECUTE: begin
                    state_q <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    pc_q       <= pc_d;
                    imem_req_q <= 1'b1;
                    state_q    <= ST_FETCH;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    imem_req_q <= 1'b0;
                    busy_q     <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign busy      = busy_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_fetch_sequencer.sv
// Bench for cpu_fetch_sequencer: instruction-level reference model plus directed programs
// with hand-computed register values and cycle counts.
module tb_cpu_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = 16'h0;
    logic        imem_valid = 1'b0;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_result = 8'h0;
    logic        busy;
    logic        halted;
    logic [1:0]  dbg_sel = 2'd0;
    logic [7:0]  dbg_data;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    cpu_fetch_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .busy       (busy),
        .halted     (halted),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << 1;
            4'd6:    return a >> 1;
            default: return 8'h0;
        endcase
    endfunction

    function automatic logic [15:0] alu_i(input logic [3:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 6'b0};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {4'd7, rd, 2'b00, imm};
    endfunction

    localparam logic [15:0] HALT = 16'hF000;
    localparam logic [15:0] NOP  = 16'h8000;

    // External ALU: registers its result every clock.
    always @(posedge clk) alu_result <= alu_fn(alu_op, alu_a, alu_b);

    // Instruction memory with a programmable number of wait cycles per fetch.
    logic [15:0] imem [256];
    int stall = 0;
    int wait_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (imem_req) begin
            if (wait_cnt >= stall) begin
                imem_valid = 1'b1;
                imem_rdata = imem[imem_addr];
                wait_cnt   = 0;
            end else begin
                imem_valid = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_valid = 1'b0;
            wait_cnt   = 0;
        end
    end

    logic [7:0] addrq [$];
    always @(negedge clk) if (imem_req && imem_valid) addrq.push_back(imem_addr);

    // Reference model: per-instruction latency and architectural effects.
    // mode 0 idle, 1 fetching, 2 executing an accepted instruction, 3 halted.
    int          m_mode = 0;
    int          m_cnt  = 0;
    bit          m_first = 1'b0;
    logic [7:0]  m_pc = 8'h0;
    logic [7:0]  m_rf [4] = '{default: 8'h0};
    logic [15:0] m_ir = 16'h0;
    logic [3:0]  m_op = 4'h0;
    logic [7:0]  m_a = 8'h0;
    logic [7:0]  m_b = 8'h0;

    function automatic int lat(input logic [3:0] op);
        if (op <= 4'd6) return 4;
        if (op == 4'd7) return 3;
        return 2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pc = 8'h0; m_cnt = 0; m_first = 1'b0;
            m_op = 4'h0; m_a = 8'h0; m_b = 8'h0;
            for (int i = 0; i < 4; i++) m_rf[i] = 8'h0;
        end else begin
            case (m_mode)
                0, 3: if (start) begin m_mode = 1; m_pc = 8'h0; end
                1: if (imem_valid) begin
                    m_ir    = imem_rdata;
                    m_cnt   = lat(m_ir[15:12]) - 1;
                    m_first = 1'b1;
                    m_mode  = 2;
                end
                default: begin
                    if (m_first && m_ir[15:12] <= 4'd6) begin
                        m_op = m_ir[15:12];
                        m_a  = m_rf[m_ir[9:8]];
                        m_b  = m_rf[m_ir[7:6]];
                    end
                    m_first = 1'b0;
                    m_cnt--;
                    if (m_cnt == 0) begin
                        if (m_ir[15:12] <= 4'd6) m_rf[m_ir[11:10]] = alu_fn(m_op, m_a, m_b);
                        else if (m_ir[15:12] == 4'd7) m_rf[m_ir[11:10]] = m_ir[7:0];
                        if (m_ir[15:12] == 4'd15) m_mode = 3;
                        else begin m_pc = m_pc + 8'd1; m_mode = 1; end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("imem_req", imem_req, m_mode == 1);
            chk("busy", busy, m_mode == 1 || m_mode == 2);
            chk("halted", halted, m_mode == 3);
            if (m_mode == 1) chk("imem_addr", imem_addr, m_pc);
            chk("alu_op", alu_op, m_op);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("dbg_data", dbg_data, m_rf[dbg_sel]);
        end
    end

    task automatic peek(input string nm, input logic [1:0] r, input logic [7:0] exp);
        @(posedge clk);
        #1 dbg_sel = r;
        #1 chk(nm, dbg_data, exp);
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < 256; i++) imem[i] = w;
    endtask

    // Pulses start; returns cycles from the first FETCH cycle until halted is seen, -1 on timeout.
    task automatic run_prog(input int poke, input bit patch, output int cyc);
        addrq.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (halted) begin cyc = k; break; end
            start = (k == poke);
            if (patch && imem_req && imem_addr == 8'd200) begin
                imem[0] = ldi(2'd3, 8'h5A);
                imem[1] = HALT;
            end
        end
        start = 1'b0;
    endtask

    function automatic int qat(input int i);
        return (addrq.size() > i) ? int'(addrq[i]) : -1;
    endfunction

    task automatic load_basic();
        fill(HALT);
        imem[0] = ldi(2'd0, 8'd10);
        imem[1] = ldi(2'd1, 8'd5);
        imem[2] = alu_i(4'd0, 2'd2, 2'd0, 2'd1);
        imem[3] = HALT;
    endtask

    int cyc;

    initial begin
        fill(HALT);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_alu_a", alu_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Basic program
        load_basic();
        run_prog(-1, 1'b0, cyc);
        chk("basic_cycles", cyc, 12);
        chk("basic_nfetch", addrq.size(), 4);
        for (int i = 0; i < 4; i++) chk("basic_addr_seq", qat(i), i);
        chk("basic_pc_hold", imem_addr, 3);
        chk("basic_alu_op", alu_op, 0);
        chk("basic_alu_a", alu_a, 10);
        chk("basic_alu_b", alu_b, 5);
        peek("basic_r2", 2'd2, 8'd15);

        // Logic ops
        fill(HALT);
        imem[0] = ldi(2'd0, 8'hAA);
        imem[1] = ldi(2'd1, 8'hCC);
        imem[2] = alu_i(4'd2, 2'd2, 2'd0, 2'd1);
        imem[3] = alu_i(4'd3, 2'd3, 2'd0, 2'd1);
        imem[4] = alu_i(4'd4, 2'd1, 2'd0, 2'd1);
        run_prog(-1, 1'b0, cyc);
        chk("logic_cycles", cyc, 20);
        peek("and_r2", 2'd2, 8'h88);
        peek("or_r3", 2'd3, 8'hEE);
        peek("xor_r1", 2'd1, 8'h66);

        // SUB and shifts
        fill(HALT);
        imem[0] = ldi(2'd0, 8'd20);
        imem[1] = ldi(2'd1, 8'd7);
        imem[2] = alu_i(4'd1, 2'd2, 2'd0, 2'd1);
        imem[3] = ldi(2'd1, 8'd25);
        imem[4] = alu_i(4'd5, 2'd3, 2'd1, 2'd1);
        imem[5] = alu_i(4'd6, 2'd0, 2'd3, 2'd3);
        run_prog(-1, 1'b0, cyc);
        chk("shift_cycles", cyc, 23);
        peek("sub_r2", 2'd2, 8'd13);
        peek("shl_r3", 2'd3, 8'd50);
        peek("shr_r0", 2'd0, 8'd25);
        chk("shr_alu_op", alu_op, 6);
        chk("shr_alu_a", alu_a, 50);

        // ADD wrap, rd aliasing rs1/rs2
        fill(HALT);
        imem[0] = ldi(2'd0, 8'd250);
        imem[1] = ldi(2'd1, 8'd10);
        imem[2] = alu_i(4'd0, 2'd2, 2'd0, 2'd1);
        imem[3] = alu_i(4'd0, 2'd0, 2'd0, 2'd0);
        run_prog(-1, 1'b0, cyc);
        chk("wrap_cycles", cyc, 16);
        peek("add_wrap_r2", 2'd2, 8'd4);
        peek("add_alias_r0", 2'd0, 8'd244);

        // Memory stall: 3 wait cycles per fetch
        stall = 3;
        load_basic();
        run_prog(-1, 1'b0, cyc);
        chk("stall_cycles", cyc, 24);
        for (int i = 0; i < 4; i++) chk("stall_addr_seq", qat(i), i);
        peek("stall_r2", 2'd2, 8'd15);
        stall = 0;

        // start while busy is ignored
        run_prog(5, 1'b0, cyc);
        chk("busy_start_cycles", cyc, 12);
        chk("busy_start_nfetch", addrq.size(), 4);

        // Restart from HALTED keeps the register file
        fill(HALT);
        run_prog(-1, 1'b0, cyc);
        chk("restart_cycles", cyc, 2);
        chk("restart_addr0", qat(0), 0);
        peek("restart_r0", 2'd0, 8'd10);
        peek("restart_r2", 2'd2, 8'd15);

        // NOP sweep and PC wrap
        fill(NOP);
        run_prog(-1, 1'b1, cyc);
        chk("nop_cycles", cyc, 517);
        chk("nop_nfetch", addrq.size(), 258);
        chk("wrap_addr255", qat(255), 255);
        chk("wrap_addr0", qat(256), 0);
        chk("wrap_addr1", qat(257), 1);
        peek("loadi_r3", 2'd3, 8'h5A);

        // Reset during EXECUTE of an ADD
        fill(HALT);
        imem[0] = ldi(2'd0, 8'd3);
        imem[1] = ldi(2'd1, 8'd4);
        imem[2] = alu_i(4'd0, 2'd2, 2'd0, 2'd1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (imem_req && imem_valid && imem_addr == 8'd2) begin seen = 1'b1; break; end
            end
            chk("mid_rst_reach_add", seen, 1);
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_alu_op", alu_op, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_pc", imem_addr, 0);
        peek("mid_rst_r2", 2'd2, 8'd0);
        peek("mid_rst_r3", 2'd3, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        peek("post_rst_r2", 2'd2, 8'd0);
        run_prog(-1, 1'b0, cyc);
        chk("post_rst_cycles", cyc, 12);
        chk("post_rst_addr0", qat(0), 0);
        peek("post_rst_r2_sum", 2'd2, 8'd7);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
